// File: rtl/bibuf_pkg.sv
// -----------------------------------------------------------------------------
// bibuf_pkg
// Shared definitions for the bidirectional pad bank controller:
//   - bibuf_state_e   : controller states (IDLE, TURN, DRIVE, RECV)
//   - turn_cnt_width  : width of the dead-time counter for a given TURN_CYCLES
//   - TURN_CNT_W      : counter width for the default TURN_CYCLES
//   - DIR_TX / DIR_RX : encodings of the DIR_REQ input
// -----------------------------------------------------------------------------
package bibuf_pkg;

    // Controller states. IDLE and TURN both release the pads.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        DRIVE = 2'd2,
        RECV  = 2'd3
    } bibuf_state_e;

    localparam int TURN_CYCLES_DEFAULT = 2;

    // The counter needs to represent 0..TURN_CYCLES. A zero-cycle
    // turnaround never uses the counter, but it still needs a legal
    // one-bit vector.
    function automatic int turn_cnt_width(input int turn_cycles);
        return (turn_cycles > 0) ? $clog2(turn_cycles + 1) : 1;
    endfunction

    localparam int TURN_CNT_W = turn_cnt_width(TURN_CYCLES_DEFAULT);

    // Direction encodings carried on DIR_REQ.
    localparam logic DIR_TX = 1'b1;
    localparam logic DIR_RX = 1'b0;

endpackage : bibuf_pkg

// File: rtl/bibuf_sync.sv
// -----------------------------------------------------------------------------
// bibuf_sync
// A WIDTH-bit wide, STAGES-deep flop chain used to synchronise the
// asynchronous pad inputs into the CLK domain. The chain only advances while
// en_i is high. When en_i is low the chain keeps its contents, so q_o holds
// the last synchronised word.
//
// Ports:
//   CLK   in   clock, rising edge
//   RST   in   synchronous active-high reset, clears every stage
//   en_i  in   shift enable
//   d_i   in   WIDTH  asynchronous input word
//   q_o   out  WIDTH  synchronised word (last stage of the chain)
// -----------------------------------------------------------------------------
module bibuf_sync
    import bibuf_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Synchroniser chain: the first stage samples the pad, and later stages
    // settle any metastability.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= {WIDTH{1'b0}};
            end
        end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule : bibuf_sync

// File: rtl/bibuf_bank.sv
// -----------------------------------------------------------------------------
// bibuf_bank
// This controller sits between the core and a row of split O/T/I pad buffers.
// It sequences direction changes with a programmable all-released dead time.
// It also registers the outbound word and synchronises the inbound word.
//
// Parameters:
//   WIDTH        pad bits (1..64)
//   TURN_CYCLES  dead cycles between directions (0..15)
//   SYNC_STAGES  inbound synchroniser depth (2..4)
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset
//   DIR_VALID  in   direction request, held until DIR_ACK
//   DIR_REQ    in   1 = drive (TX), 0 = receive (RX)
//   DIR_ACK    out  one-cycle pulse when the requested direction is live
//   TX_DATA    in   outbound word
//   TX_VALID   in   outbound word valid
//   TX_READY   out  bank accepts TX_DATA (high throughout DRIVE)
//   RX_DATA    out  synchronised inbound word
//   RX_VALID   out  RX_DATA is a valid sample
//   PAD_O      out  buffer O inputs
//   PAD_T      out  buffer T inputs, 1 = high-Z
//   PAD_I      in   buffer I outputs (asynchronous)
//   BUSY       out  high while in TURN
//
// All outputs come from flops. Each output register is loaded from the
// decode of state_d, so its value always matches state_q in the same cycle.
// -----------------------------------------------------------------------------
module bibuf_bank
    import bibuf_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             DIR_VALID,
    input  logic             DIR_REQ,
    output logic             DIR_ACK,
    input  logic [WIDTH-1:0] TX_DATA,
    input  logic             TX_VALID,
    output logic             TX_READY,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             RX_VALID,
    output logic [WIDTH-1:0] PAD_O,
    output logic [WIDTH-1:0] PAD_T,
    input  logic [WIDTH-1:0] PAD_I,
    output logic             BUSY
);

    localparam int CNT_W  = turn_cnt_width(TURN_CYCLES);
    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    // Last counter value spent in TURN before the new direction is entered.
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((TURN_CYCLES > 0) ? (TURN_CYCLES - 1) : 0);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_STAGES);

    // A crossing (DRIVE <-> RECV, or IDLE -> DRIVE) goes through TURN.
    // With a zero dead time it lands in the target state directly.
    localparam bibuf_state_e TX_CROSS = (TURN_CYCLES == 0) ? DRIVE : TURN;
    localparam bibuf_state_e RX_CROSS = (TURN_CYCLES == 0) ? RECV  : TURN;

    bibuf_state_e      state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              tgt_q,      tgt_d;
    logic [FILL_W-1:0] fill_q,     fill_d;
    logic [WIDTH-1:0]  pad_o_q,    pad_o_d;
    logic [WIDTH-1:0]  pad_t_q,    pad_t_d;
    logic              tx_ready_q, tx_ready_d;
    logic              rx_valid_q, rx_valid_d;
    logic              dir_ack_q,  dir_ack_d;
    logic              busy_q,     busy_d;

    logic              req_s;
    logic              sync_en_s;
    logic [WIDTH-1:0]  rx_sync_s;

    // The requester only sees DIR_ACK one cycle late. During the acknowledge
    // cycle it is still holding DIR_VALID, so that request is already
    // consumed and must not be taken again.
    assign req_s = DIR_VALID & ~dir_ack_q;

    // State register, together with the TURN bookkeeping that is
    // sequenced alongside it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            tgt_q   <= DIR_RX;
            fill_q  <= {FILL_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            fill_q  <= fill_d;
        end
    end

    // Next-state logic. DIR_VALID is not looked at while in TURN.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    if (DIR_REQ == DIR_TX) begin
                        tgt_d   = DIR_TX;
                        state_d = TX_CROSS;
                    end else begin
                        // Pads are already released, so there is no
                        // contention and no dead time is needed.
                        tgt_d   = DIR_RX;
                        state_d = RECV;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            TURN: begin
                if (cnt_q >= CNT_LAST) begin
                    state_d = (tgt_q == DIR_TX) ? DRIVE : RECV;
                end else begin
                    state_d = TURN;
                end
            end
            DRIVE: begin
                if (req_s && (DIR_REQ == DIR_RX)) begin
                    tgt_d   = DIR_RX;
                    state_d = RX_CROSS;
                end else begin
                    state_d = DRIVE;
                end
            end
            RECV: begin
                if (req_s && (DIR_REQ == DIR_TX)) begin
                    tgt_d   = DIR_TX;
                    state_d = TX_CROSS;
                end else begin
                    state_d = RECV;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and datapath next values, decoded from the upcoming state.
    always_comb begin
        // Dead-time counter runs only for consecutive TURN cycles.
        if ((state_q == TURN) && (state_d == TURN)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end

        // Fill counter: each cycle that stays in RECV pushes one sample
        // into the synchroniser. The count saturates once the chain is full
        // and clears whenever RECV is left.
        if ((state_q == RECV) && (state_d == RECV)) begin
            if (fill_q < FILL_FULL) begin
                fill_d = fill_q + FILL_W'(1);
            end else begin
                fill_d = fill_q;
            end
        end else begin
            fill_d = {FILL_W{1'b0}};
        end

        if (state_d == DRIVE) begin
            pad_t_d = {WIDTH{1'b0}};
        end else begin
            pad_t_d = {WIDTH{1'b1}};
        end

        tx_ready_d = (state_d == DRIVE);
        busy_d     = (state_d == TURN);
        rx_valid_d = (state_d == RECV) && (fill_d >= FILL_FULL);

        // Acknowledge on entry to a direction, or one cycle after a request
        // for the direction already in force.
        dir_ack_d = ((state_d == DRIVE) && (state_q != DRIVE)) ||
                    ((state_d == RECV)  && (state_q != RECV))  ||
                    ((state_q == DRIVE) && (state_d == DRIVE) && req_s && (DIR_REQ == DIR_TX)) ||
                    ((state_q == RECV)  && (state_d == RECV)  && req_s && (DIR_REQ == DIR_RX));

        // PAD_O follows the TX handshake only, so after DRIVE it keeps the
        // last accepted word.
        if (tx_ready_q && TX_VALID) begin
            pad_o_d = TX_DATA;
        end else begin
            pad_o_d = pad_o_q;
        end
    end

    // Registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pad_o_q    <= {WIDTH{1'b0}};
            pad_t_q    <= {WIDTH{1'b1}};
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            dir_ack_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            pad_o_q    <= pad_o_d;
            pad_t_q    <= pad_t_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            dir_ack_q  <= dir_ack_d;
            busy_q     <= busy_d;
        end
    end

    // The synchroniser advances only while RECV persists. On the exit cycle
    // it does not shift, so RX_DATA keeps the last word presented as valid.
    assign sync_en_s = (state_q == RECV) && (state_d == RECV);

    bibuf_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .CLK  (CLK),
        .RST  (RST),
        .en_i (sync_en_s),
        .d_i  (PAD_I),
        .q_o  (rx_sync_s)
    );

    assign DIR_ACK  = dir_ack_q;
    assign TX_READY = tx_ready_q;
    assign RX_DATA  = rx_sync_s;
    assign RX_VALID = rx_valid_q;
    assign PAD_O    = pad_o_q;
    assign PAD_T    = pad_t_q;
    assign BUSY     = busy_q;

endmodule : bibuf_bank

// File: tb/tb_bibuf_bank.sv
// -----------------------------------------------------------------------------
// tb_bibuf_bank
// Directed stimulus with a scoreboard. The stimulus pushes the expected
// DIR_ACK, PAD_O and RX_DATA events, each with the cycle it should occur in.
// A negedge monitor pops an entry whenever the DUT presents the matching
// output and compares it. The stimulus also checks some levels directly,
// 1 ns after the rising edge. Cycle k is the period that follows the k-th
// rising edge.
// -----------------------------------------------------------------------------
module tb_bibuf_bank;

    localparam int WIDTH = 8;

    logic             CLK;
    logic             RST;
    logic             DIR_VALID;
    logic             DIR_REQ;
    logic             DIR_ACK;
    logic [WIDTH-1:0] TX_DATA;
    logic             TX_VALID;
    logic             TX_READY;
    logic [WIDTH-1:0] RX_DATA;
    logic             RX_VALID;
    logic [WIDTH-1:0] PAD_O;
    logic [WIDTH-1:0] PAD_T;
    logic [WIDTH-1:0] PAD_I;
    logic             BUSY;

    bibuf_bank #(
        .WIDTH       (WIDTH),
        .TURN_CYCLES (2),
        .SYNC_STAGES (2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .DIR_VALID (DIR_VALID),
        .DIR_REQ   (DIR_REQ),
        .DIR_ACK   (DIR_ACK),
        .TX_DATA   (TX_DATA),
        .TX_VALID  (TX_VALID),
        .TX_READY  (TX_READY),
        .RX_DATA   (RX_DATA),
        .RX_VALID  (RX_VALID),
        .PAD_O     (PAD_O),
        .PAD_T     (PAD_T),
        .PAD_I     (PAD_I),
        .BUSY      (BUSY)
    );

    typedef struct {
        int             cyc;
        logic [7:0]     pad_t;
        logic           tx_ready;
    } ack_exp_t;

    typedef struct {
        int             cyc;
        logic [7:0]     data;
    } word_exp_t;

    ack_exp_t  ack_exp[$];
    word_exp_t tx_exp[$];
    word_exp_t rx_exp[$];

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    logic tx_hs_prev = 1'b0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic exp_ack(input int c, input logic [7:0] pt, input logic tr);
        ack_exp.push_back('{cyc: c, pad_t: pt, tx_ready: tr});
    endtask

    task automatic exp_tx(input int c, input logic [7:0] d);
        tx_exp.push_back('{cyc: c, data: d});
    endtask

    task automatic exp_rx(input int c, input logic [7:0] d);
        rx_exp.push_back('{cyc: c, data: d});
    endtask

    // Monitor: consumes scoreboard entries as the DUT presents outputs and
    // checks the invariants every cycle.
    always @(negedge CLK) begin
        ack_exp_t  a;
        word_exp_t w;
        if (DIR_ACK) begin
            if (ack_exp.size() == 0) begin
                chk("dir_ack_unexpected", 64'(DIR_ACK), 64'd0);
            end else begin
                a = ack_exp.pop_front();
                chk("dir_ack_cycle", 64'(cyc), 64'(a.cyc));
                chk("dir_ack_pad_t", 64'(PAD_T), 64'(a.pad_t));
                chk("dir_ack_tx_ready", 64'(TX_READY), 64'(a.tx_ready));
            end
        end
        if (RX_VALID) begin
            if (rx_exp.size() == 0) begin
                chk("rx_valid_unexpected", 64'(RX_VALID), 64'd0);
            end else begin
                w = rx_exp.pop_front();
                chk("rx_cycle", 64'(cyc), 64'(w.cyc));
                chk("rx_data", 64'(RX_DATA), 64'(w.data));
            end
        end
        if (tx_hs_prev) begin
            if (tx_exp.size() == 0) begin
                chk("tx_unexpected", 64'(PAD_O), 64'd0);
            end else begin
                w = tx_exp.pop_front();
                chk("tx_cycle", 64'(cyc), 64'(w.cyc));
                chk("tx_pad_o", 64'(PAD_O), 64'(w.data));
            end
        end
        tx_hs_prev = TX_VALID && TX_READY && !RST;
        chk("ack_not_busy", 64'(DIR_ACK && BUSY), 64'd0);
        chk("ready_valid_excl", 64'(TX_READY && RX_VALID), 64'd0);
        chk("pad_t_uniform", 64'((PAD_T == 8'h00) || (PAD_T == 8'hFF)), 64'd1);
    end

    initial begin
        int n;
        int m;
        int p;
        RST       = 1'b1;
        DIR_VALID = 1'b1;
        DIR_REQ   = 1'b1;
        TX_DATA   = 8'h00;
        TX_VALID  = 1'b0;
        PAD_I     = 8'hFF;

        // Reset held three cycles with a pending request and busy pads.
        repeat (3) tick();
        chk("rst_pad_t", 64'(PAD_T), 64'hFF);
        chk("rst_pad_o", 64'(PAD_O), 64'h00);
        chk("rst_dir_ack", 64'(DIR_ACK), 64'd0);
        chk("rst_tx_ready", 64'(TX_READY), 64'd0);
        chk("rst_rx_valid", 64'(RX_VALID), 64'd0);
        chk("rst_rx_data", 64'(RX_DATA), 64'h00);
        chk("rst_busy", 64'(BUSY), 64'd0);
        RST       = 1'b0;
        DIR_VALID = 1'b0;
        DIR_REQ   = 1'b0;
        PAD_I     = 8'h5A;

        // IDLE -> RECV directly; data valid two cycles after entry.
        tick();
        n = cyc;
        DIR_VALID = 1'b1;
        DIR_REQ   = 1'b0;
        exp_ack(n + 1, 8'hFF, 1'b0);
        exp_rx(n + 3, 8'h5A);
        exp_rx(n + 4, 8'h5A);
        exp_rx(n + 5, 8'h5A);
        exp_rx(n + 6, 8'hC3);
        exp_rx(n + 7, 8'hC3);
        tick();                                 // n+1: RECV entry
        DIR_VALID = 1'b0;
        chk("recv_entry_busy", 64'(BUSY), 64'd0);
        tick();                                 // n+2: TX offer while not ready
        TX_VALID = 1'b1;
        TX_DATA  = 8'hEE;
        tick();                                 // n+3
        TX_VALID = 1'b0;
        tick();                                 // n+4
        PAD_I = 8'hC3;
        repeat (3) tick();                      // n+7

        // RECV -> TURN(2) -> DRIVE.
        m = cyc;
        DIR_VALID = 1'b1;
        DIR_REQ   = 1'b1;
        exp_ack(m + 3, 8'h00, 1'b1);
        exp_tx(m + 4, 8'hA5);
        exp_tx(m + 5, 8'h3C);
        tick();                                 // m+1: first TURN cycle
        chk("turn1_busy", 64'(BUSY), 64'd1);
        chk("turn1_pad_t", 64'(PAD_T), 64'hFF);
        chk("turn1_tx_ready", 64'(TX_READY), 64'd0);
        chk("turn1_rx_data_hold", 64'(RX_DATA), 64'hC3);
        tick();                                 // m+2
        chk("turn2_busy", 64'(BUSY), 64'd1);
        chk("turn2_pad_t", 64'(PAD_T), 64'hFF);
        tick();                                 // m+3: DRIVE entry
        chk("drive_busy", 64'(BUSY), 64'd0);
        chk("drive_pad_t", 64'(PAD_T), 64'h00);
        chk("drive_pad_o_untouched", 64'(PAD_O), 64'h00);
        DIR_VALID = 1'b0;
        TX_VALID  = 1'b1;
        TX_DATA   = 8'hA5;
        tick();                                 // m+4
        TX_DATA = 8'h3C;
        tick();                                 // m+5
        TX_VALID = 1'b0;
        tick();                                 // m+6: same-direction request
        DIR_VALID = 1'b1;
        DIR_REQ   = 1'b1;
        exp_ack(m + 7, 8'h00, 1'b1);
        tick();                                 // m+7
        DIR_VALID = 1'b0;
        chk("same_dir_busy", 64'(BUSY), 64'd0);
        chk("same_dir_pad_t", 64'(PAD_T), 64'h00);
        repeat (2) tick();                      // m+9

        // DRIVE -> TURN(2) -> RECV.
        DIR_VALID = 1'b1;
        DIR_REQ   = 1'b0;
        PAD_I     = 8'h96;
        exp_ack(m + 12, 8'hFF, 1'b0);
        exp_rx(m + 14, 8'h96);
        exp_rx(m + 15, 8'h96);
        tick();                                 // m+10
        chk("leave_drive_pad_t", 64'(PAD_T), 64'hFF);
        chk("leave_drive_tx_ready", 64'(TX_READY), 64'd0);
        chk("leave_drive_busy", 64'(BUSY), 64'd1);
        chk("leave_drive_pad_o_hold", 64'(PAD_O), 64'h3C);
        repeat (2) tick();                      // m+12
        DIR_VALID = 1'b0;
        repeat (3) tick();                      // m+15

        // Drive request, then reset on the first TURN cycle.
        p = cyc;
        DIR_VALID = 1'b1;
        DIR_REQ   = 1'b1;
        tick();                                 // p+1
        chk("pre_rst_busy", 64'(BUSY), 64'd1);
        RST       = 1'b1;
        DIR_VALID = 1'b0;
        tick();                                 // p+2
        chk("mid_turn_rst_pad_t", 64'(PAD_T), 64'hFF);
        chk("mid_turn_rst_busy", 64'(BUSY), 64'd0);
        chk("mid_turn_rst_dir_ack", 64'(DIR_ACK), 64'd0);
        chk("mid_turn_rst_tx_ready", 64'(TX_READY), 64'd0);
        chk("mid_turn_rst_rx_valid", 64'(RX_VALID), 64'd0);
        chk("mid_turn_rst_pad_o", 64'(PAD_O), 64'h00);
        chk("mid_turn_rst_rx_data", 64'(RX_DATA), 64'h00);
        RST = 1'b0;
        repeat (2) tick();                      // p+4: still IDLE
        chk("post_rst_idle_pad_t", 64'(PAD_T), 64'hFF);
        chk("post_rst_idle_busy", 64'(BUSY), 64'd0);
        repeat (2) tick();

        chk("ack_queue_drained", 64'(ack_exp.size()), 64'd0);
        chk("tx_queue_drained", 64'(tx_exp.size()), 64'd0);
        chk("rx_queue_drained", 64'(rx_exp.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bibuf_bank
